uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART Transmitter among NUM_REQ byte producers.
//  - Round-robin arbitration; latches the winner's byte.
//  - Drives the Transmitter's transmit/data inputs and times the full frame with a local bit counter.
//  - Sits between the client logic and Transmitter in the UART top level.
// PARAMETERS
//  NUM_REQ       4      number of requesters (2..8)
//  CLKS_PER_BIT  10416  clk cycles per UART bit (100 MHz / 9600 baud); must match Transmitter
//  FRAME_BITS    10     bits per frame (start + 8 data + stop)
// PORTS
//  clk       in   1          system clock, rising edge
//  reset     in   1          asynchronous reset, active-low
//  req       in   NUM_REQ    level request; req[i] high = byte pending on requester i
//  req_data  in   8*NUM_REQ  byte of requester i on bits [8*i+7:8*i]
//  grant     out  NUM_REQ    one-hot, 1-cycle pulse: byte of requester i accepted
//  tx_data   out  8          byte to Transmitter data input
//  tx_start  out  1          to Transmitter transmit input
//  busy      out  1          high while a frame is in progress (LOAD..SEND/WAIT)
//  tx_done   out  1          1-cycle pulse at end of frame
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - state=IDLE; grant=0, tx_data=8'h00, tx_start=0, busy=0, tx_done=0.
//    - bit_cnt=0, clk_cnt=0; last=NUM_REQ-1, so index 0 wins first.
//  - All outputs registered.
//  - IDLE:
//    - If any req bit is set, winner = first set index searching last+1, last+2, ... modulo NUM_REQ.
//    - Next edge: go to LOAD; tx_data <= req_data[winner]; grant[winner]=1; last <= winner; busy=1; tx_start=1.
//    - Latency: req sampled high in IDLE -> grant and tx_start high one edge later.
//  - LOAD (1 cycle): grant returns to 0. Next state SEND.
//  - SEND:
//    - tx_start is held high for exactly CLKS_PER_BIT cycles, counted from entry to LOAD, then drops.
//    - Then go to WAIT.
//  - WAIT:
//    - clk_cnt counts 0..CLKS_PER_BIT-1; bit_cnt increments on each clk_cnt wrap.
//    - When bit_cnt reaches FRAME_BITS: tx_done=1 for one cycle, busy=0, state=IDLE.
//    - Total frame from LOAD entry = FRAME_BITS*CLKS_PER_BIT cycles.
//  - Counter widths: clk_cnt = $clog2(CLKS_PER_BIT); bit_cnt = $clog2(FRAME_BITS+1). Both wrap to 0 on frame end.
//  - tx_data is stable from LOAD until the next LOAD; it does not change in IDLE.
//  - Boundary cases:
//    - req dropped after grant: no effect; the frame completes with the latched byte.
//    - req dropped before sampling in IDLE: not served; no grant.
//    - req changes during a frame: ignored until IDLE.
//    - Several req bits set: one grant per frame. Back-to-back frames have a 1-cycle IDLE gap (tx_done cycle), then arbitration.
//    - Requester continuously requesting: it gets at most one frame per round when others also request.
//    - reset asserted mid-frame: all outputs go to reset values immediately; the partial frame is abandoned.
//    - req_data of non-winners is never sampled.
// CONFIGURATION
//  UART_ARB_FIXED_PRIO_EN
//    - Defined: fixed priority. Lowest set index always wins; `last` register omitted.
//    - Undefined (default): round-robin as above.
//    - Timing and handshake are identical in both modes.
// TESTING (sim with CLKS_PER_BIT=4, FRAME_BITS=10 -> 40-cycle frame)
//  1. req=4'b0001, data0=8'hA5 -> next edge grant=0001, tx_data=A5, tx_start high 4 cycles, tx_done 40 cycles after LOAD.
//  2. req=4'b1111 held, data i=8'h10+i -> grants 0,1,2,3,0 in order; tx_data 10,11,12,13,10; each 41 cycles apart.
//  3. Same as 2 with UART_ARB_FIXED_PRIO_EN -> grant always 0001, tx_data always 10.
//  4. req=4'b0100 one cycle in IDLE then 0 -> single frame with data2; no further grant.
//  5. reset low at cycle 20 of a frame -> same cycle tx_start=0, busy=0; after release, pending req=0010 -> grant=0010 and a full 40-cycle frame.
//  6. req=4'b1000 while busy from req0 -> grant=1000 exactly one cycle after tx_done.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN to use fixed (lowest index wins) priority instead.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned FRAME_BITS   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = $clog2(FRAME_BITS + 1);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] WAIT = 2'd3;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               tx_done_q, tx_done_d;

    logic               found;
    logic [IW-1:0]      winner;
    logic               clk_wrap;
    logic               frame_end;

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] last_q, last_d;

    // Search starts just after the previous winner, so the last winner has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int off = 1; off <= int'(NUM_REQ); off++) begin
            if (!found && req[(int'(last_q) + off) % int'(NUM_REQ)]) begin
                found  = 1'b1;
                winner = IW'((int'(last_q) + off) % int'(NUM_REQ));
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && found) begin
            last_d = winner;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= IW'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign clk_wrap  = (clk_cnt_q == CLK_LAST);
    assign frame_end = clk_wrap && (bit_cnt_q == BIT_LAST);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        grant_d    = '0;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        busy_d     = busy_q;
        tx_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = LOAD;
                    grant_d    = NUM_REQ'(1) << winner;
                    tx_data_d  = req_data[8*int'(winner) +: 8];
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                end
            end
            LOAD, SEND, WAIT: begin
                if (clk_wrap) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end

                // First bit period elapsed: the transmitter has latched the start request.
                if (clk_wrap && bit_cnt_q == '0) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT;
                end else if (state_q == LOAD) begin
                    state_d = SEND;
                end

                if (frame_end) begin
                    state_d    = IDLE;
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    tx_start_d = 1'b0;
                    busy_d     = 1'b0;
                    tx_done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            grant_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (4 requesters, 4 clocks/bit, 10-bit frame).
module tb_uart_tx_arbiter;

    localparam int unsigned NR    = 4;
    localparam int unsigned CPB   = 4;
    localparam int unsigned FB    = 10;
    localparam int          FRAME = CPB * FB;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [31:0]   req_data;
    logic [NR-1:0] grant;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          busy;
    logic          tx_done;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (NR),
        .CLKS_PER_BIT(CPB),
        .FRAME_BITS  (FB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_data(req_data),
        .grant   (grant),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .busy    (busy),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  g_rr;
        logic [7:0]  d_rr;
        logic [3:0]  g_fx;
        logic [7:0]  d_fx;
    } vec_t;

    vec_t tbl[8];

    localparam logic [31:0] DATA_DEF = 32'h1312_1110;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Called on the falling edge right after the granting edge; returns on the tx_done cycle.
    task automatic check_frame(input logic [3:0] eg, input logic [7:0] ed,
                               input logic [3:0] mid, input string nm);
        int hi;
        int done_at;
        int glitch;
        chk({nm, " grant"}, 32'(grant), 32'(eg));
        chk({nm, " tx_data"}, 32'(tx_data), 32'(ed));
        chk({nm, " tx_start"}, 32'(tx_start), 32'd1);
        chk({nm, " busy"}, 32'(busy), 32'd1);
        req     = mid;
        hi      = 1;
        done_at = 0;
        glitch  = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (tx_start) hi++;
            if (tx_start != (k < int'(CPB))) glitch++;
            if (grant != '0 || tx_data != ed) glitch++;
            if (tx_done) begin
                done_at = k;
                break;
            end
            if (!busy) glitch++;
        end
        chk({nm, " tx_done cycle"}, 32'(done_at), 32'(FRAME));
        chk({nm, " tx_start cycles"}, 32'(hi), 32'(CPB));
        chk({nm, " in-frame glitches"}, 32'(glitch), 32'd0);
        chk({nm, " busy at done"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req      = '0;
        req_data = DATA_DEF;
        repeat (3) @(negedge clk);
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        chk("reset tx_start", 32'(tx_start), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset tx_done", 32'(tx_done), 32'd0);
        reset = 1'b1;
    endtask

    logic [3:0] g_exp;
    logic [7:0] d_exp;
    int         stray;

    initial begin
        reset    = 1'b0;
        req      = '0;
        req_data = DATA_DEF;

        tbl[0] = '{4'b0001, 32'h1312_11A5, 4'b0001, 8'hA5, 4'b0001, 8'hA5};
        tbl[1] = '{4'b1111, DATA_DEF,      4'b0010, 8'h11, 4'b0001, 8'h10};
        tbl[2] = '{4'b1111, DATA_DEF,      4'b0100, 8'h12, 4'b0001, 8'h10};
        tbl[3] = '{4'b1111, DATA_DEF,      4'b1000, 8'h13, 4'b0001, 8'h10};
        tbl[4] = '{4'b1111, DATA_DEF,      4'b0001, 8'h10, 4'b0001, 8'h10};
        tbl[5] = '{4'b1001, DATA_DEF,      4'b1000, 8'h13, 4'b0001, 8'h10};
        tbl[6] = '{4'b0110, DATA_DEF,      4'b0010, 8'h11, 4'b0010, 8'h11};
        tbl[7] = '{4'b0011, DATA_DEF,      4'b0001, 8'h10, 4'b0001, 8'h10};

        do_reset();

        // Single-frame vectors; request dropped right after grant.
        for (int i = 0; i < 8; i++) begin
            req      = tbl[i].req;
            req_data = tbl[i].data;
`ifdef UART_ARB_FIXED_PRIO_EN
            g_exp = tbl[i].g_fx;
            d_exp = tbl[i].d_fx;
`else
            g_exp = tbl[i].g_rr;
            d_exp = tbl[i].d_rr;
`endif
            @(negedge clk);
            check_frame(g_exp, d_exp, 4'b0000, $sformatf("vec%0d", i));
        end

        // All four held: back-to-back frames, next grant one cycle after tx_done.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
`ifdef UART_ARB_FIXED_PRIO_EN
            g_exp = 4'b0001;
            d_exp = 8'h10;
`else
            g_exp = 4'b0001 << (i % 4);
            d_exp = 8'h10 + 8'(i % 4);
`endif
            check_frame(g_exp, d_exp, (i == 4) ? 4'b0000 : 4'b1111, $sformatf("hold%0d", i));
        end

        // One-cycle request: a single frame, then silence.
        req = 4'b0100;
        @(negedge clk);
        check_frame(4'b0100, 8'h12, 4'b0000, "pulse");
        stray = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (grant != '0 || busy) stray++;
        end
        chk("pulse no regrant", 32'(stray), 32'd0);

        // Request raised and dropped between edges is never sampled.
        req = 4'b0001;
        #1 req = 4'b0000;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant != '0 || busy) stray++;
        end
        chk("unsampled req", 32'(stray), 32'd0);

        // Requester 3 arrives mid-frame; it is granted exactly one cycle after tx_done.
        req = 4'b0001;
        @(negedge clk);
        check_frame(4'b0001, 8'h10, 4'b1000, "busy0");
        @(negedge clk);
        check_frame(4'b1000, 8'h13, 4'b0000, "after_done");

        // Reset 20 cycles into a frame abandons it; pending request 1 is served afterwards.
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        chk("pre-abort grant", 32'(grant), 32'b0001);
        req = 4'b0010;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort tx_start", 32'(tx_start), 32'd0);
        chk("abort tx_data", 32'(tx_data), 32'd0);
        chk("abort tx_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_frame(4'b0010, 8'h11, 4'b0000, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
